// File: rtl/cla_sub_pipe_16bit.sv
// 16-bit subtractor built as a four-stage pipeline of 4-bit carry-lookahead slices.
// Computes D = A + ~B + ~bin one nibble per stage with valid/ready flow control.
module cla_sub_pipe_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] D,
  output logic        bout,
  output logic        ovf,
  output logic        zero
);

  typedef struct packed {
    logic       cout;
    logic [3:0] sum;
  } cla4_t;

  // Group generate/propagate form the slice carry-out without rippling through the bits.
  function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       grpP;
    logic       grpG;
    cla4_t      r;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grpG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grpP = &p;
    r.sum  = p ^ c;
    r.cout = grpG | (grpP & cin);
    return r;
  endfunction

  logic        advance;

  logic        v0_q, v1_q, v2_q, v3_q;
  logic        v0_d, v1_d, v2_d, v3_d;

  logic        carry0_q, carry1_q, carry2_q;
  logic        carry0_d, carry1_d, carry2_d;

  logic [3:0]  diff0_q, diff0_d;
  logic [7:0]  diff1_q, diff1_d;
  logic [11:0] diff2_q, diff2_d;

  logic [15:4]  opA0_q, opA0_d, opNb0_q, opNb0_d;
  logic [15:8]  opA1_q, opA1_d, opNb1_q, opNb1_d;
  logic [15:12] opA2_q, opA2_d, opNb2_q, opNb2_d;

  logic [15:0] diff3_q, diff3_d;
  logic        bout3_q, bout3_d;
  logic        ovf3_q, ovf3_d;
  logic        zero3_q, zero3_d;

  cla4_t s0, s1, s2, s3;

  assign advance  = out_ready | ~v3_q;
  assign in_ready = advance;

  assign s0 = cla4(A[3:0], ~B[3:0], ~bin);
  assign s1 = cla4(opA0_q[7:4], opNb0_q[7:4], carry0_q);
  assign s2 = cla4(opA1_q[11:8], opNb1_q[11:8], carry1_q);
  assign s3 = cla4(opA2_q[15:12], opNb2_q[15:12], carry2_q);

  // The last stage is cleared when its source is a bubble so outputs read 0 while invalid.
  always_comb begin
    v0_d     = in_valid & advance;
    v1_d     = v0_q;
    v2_d     = v1_q;
    v3_d     = v2_q;

    carry0_d = s0.cout;
    diff0_d  = s0.sum;
    opA0_d   = A[15:4];
    opNb0_d  = ~B[15:4];

    carry1_d = s1.cout;
    diff1_d  = {s1.sum, diff0_q};
    opA1_d   = opA0_q[15:8];
    opNb1_d  = opNb0_q[15:8];

    carry2_d = s2.cout;
    diff2_d  = {s2.sum, diff1_q};
    opA2_d   = opA1_q[15:12];
    opNb2_d  = opNb1_q[15:12];

    diff3_d  = '0;
    bout3_d  = 1'b0;
    ovf3_d   = 1'b0;
    zero3_d  = 1'b0;
    if (v2_q) begin
      diff3_d = {s3.sum, diff2_q};
      bout3_d = ~s3.cout;
      ovf3_d  = (opA2_q[15] ^ ~opNb2_q[15]) & (s3.sum[3] ^ opA2_q[15]);
      zero3_d = ({s3.sum, diff2_q} == 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      carry0_q <= 1'b0;
      carry1_q <= 1'b0;
      carry2_q <= 1'b0;
      diff0_q  <= '0;
      diff1_q  <= '0;
      diff2_q  <= '0;
      opA0_q   <= '0;
      opNb0_q  <= '0;
      opA1_q   <= '0;
      opNb1_q  <= '0;
      opA2_q   <= '0;
      opNb2_q  <= '0;
      diff3_q  <= '0;
      bout3_q  <= 1'b0;
      ovf3_q   <= 1'b0;
      zero3_q  <= 1'b0;
    end else if (advance) begin
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      carry0_q <= carry0_d;
      carry1_q <= carry1_d;
      carry2_q <= carry2_d;
      diff0_q  <= diff0_d;
      diff1_q  <= diff1_d;
      diff2_q  <= diff2_d;
      opA0_q   <= opA0_d;
      opNb0_q  <= opNb0_d;
      opA1_q   <= opA1_d;
      opNb1_q  <= opNb1_d;
      opA2_q   <= opA2_d;
      opNb2_q  <= opNb2_d;
      diff3_q  <= diff3_d;
      bout3_q  <= bout3_d;
      ovf3_q   <= ovf3_d;
      zero3_q  <= zero3_d;
    end
  end

  assign out_valid = v3_q;
  assign D         = diff3_q;
  assign bout      = bout3_q;
  assign ovf       = ovf3_q;
  assign zero      = zero3_q;

endmodule

// File: tb/tb_cla_sub_pipe_16bit.sv
// Directed self-checking bench for cla_sub_pipe_16bit: latency, flags, bubbles,
// back-to-back flow with a downstream stall, and reset in the middle of traffic.
module tb_cla_sub_pipe_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        bout;
  logic        ovf;
  logic        zero;

  int passCount = 0;
  int checkCount = 0;

  cla_sub_pipe_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic bi);
    in_valid = v;
    A        = a;
    B        = b;
    bin      = bi;
  endtask

  // Reset forces outputs low and in_ready high with no clock edge needed.
  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    #2;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== 20'h0)
      $display("[TB] FAIL reset_outputs: got valid=%b D=%0d bout=%b ovf=%b zero=%b required all 0",
               out_valid, D, bout, ovf, zero);
    else passCount++;
    checkCount++;
    if (in_ready !== 1'b1)
      $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
    else passCount++;
    drive(1'b1, 16'd1036, 16'd414, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkCount++;
    if ({out_valid, D} !== 17'h0)
      $display("[TB] FAIL reset_held: got valid=%b D=%0d required valid=0 D=0", out_valid, D);
    else passCount++;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One beat through an empty pipe: absent after 3 edges, present after the 4th, gone after the 5th.
  task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic bi, input logic [15:0] eD, input logic eB,
                             input logic eO, input logic eZ);
    out_ready = 1'b1;
    drive(1'b1, a, b, bi);
    @(posedge clk);
    #1;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (out_valid !== 1'b0)
      $display("[TB] FAIL %s_early: got valid=%b required 0", name, out_valid);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== {1'b1, eD, eB, eO, eZ})
      $display("[TB] FAIL %s: got valid=%b D=%0d bout=%b ovf=%b zero=%b required valid=1 D=%0d bout=%b ovf=%b zero=%b",
               name, out_valid, D, bout, ovf, zero, eD, eB, eO, eZ);
    else passCount++;
    @(posedge clk);
    #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== 20'h0)
      $display("[TB] FAIL %s_drain: got valid=%b D=%0d bout=%b ovf=%b zero=%b required all 0",
               name, out_valid, D, bout, ovf, zero);
    else passCount++;
  endtask

  // Beat, bubble, beat: the bubble must surface as an invalid, zeroed slot between results.
  task automatic test_bubbles();
    out_ready = 1'b1;
    drive(1'b1, 16'd100, 16'd1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd7, 16'd9, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== {1'b1, 16'd99, 3'b000})
      $display("[TB] FAIL bubble_first: got valid=%b D=%0d bout=%b required valid=1 D=99 bout=0",
               out_valid, D, bout);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== 20'h0)
      $display("[TB] FAIL bubble_gap: got valid=%b D=%0d required valid=0 D=0", out_valid, D);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero} !== {1'b1, 16'd65534, 3'b100})
      $display("[TB] FAIL bubble_second: got valid=%b D=%0d bout=%b ovf=%b required valid=1 D=65534 bout=1 ovf=0",
               out_valid, D, bout, ovf);
    else passCount++;
    @(posedge clk); #1;
  endtask

  // Five beats back to back; downstream stalls for cycles 4..6 as the first result appears.
  task automatic test_back_to_back();
    logic [15:0] tA [5]    = '{16'd1036, 16'd5045, 16'd32768, 16'd0, 16'd65535};
    logic [15:0] tB [5]    = '{16'd414, 16'd45042, 16'd1, 16'd0, 16'd65535};
    logic        tBin [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] eD [5]    = '{16'd622, 16'd25539, 16'd32767, 16'd65535, 16'd0};
    logic        eBout [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        eOvf [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eZero [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int sent = 0;
    int got = 0;
    int extra = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 5) drive(1'b1, tA[sent], tB[sent], tBin[sent]);
      else drive(1'b0, 16'd0, 16'd0, 1'b0);
      #1;
      if (cyc < 4) begin
        checkCount++;
        if (in_ready !== 1'b1)
          $display("[TB] FAIL b2b_in_ready_c%0d: got %b required 1", cyc, in_ready);
        else passCount++;
      end
      if (cyc >= 4 && cyc <= 6) begin
        checkCount++;
        if ({out_valid, in_ready, D, bout, ovf, zero} !== {1'b1, 1'b0, 16'd622, 3'b000})
          $display("[TB] FAIL b2b_stall_c%0d: got valid=%b in_ready=%b D=%0d required valid=1 in_ready=0 D=622",
                   cyc, out_valid, in_ready, D);
        else passCount++;
      end
      if (out_valid && out_ready) begin
        checkCount++;
        if ({D, bout, ovf, zero} !== {eD[got], eBout[got], eOvf[got], eZero[got]})
          $display("[TB] FAIL b2b_result%0d: got D=%0d bout=%b ovf=%b zero=%b required D=%0d bout=%b ovf=%b zero=%b",
                   got, D, bout, ovf, zero, eD[got], eBout[got], eOvf[got], eZero[got]);
        else passCount++;
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    checkCount++;
    if (got != 5)
      $display("[TB] FAIL b2b_count: got %0d results required 5", got);
    else passCount++;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      @(posedge clk);
      #1;
    end
    checkCount++;
    if (extra != 0)
      $display("[TB] FAIL b2b_duplicate: got %0d extra results required 0", extra);
    else passCount++;
  endtask

  // Asynchronous reset between edges wipes in-flight beats; a fresh beat then flows normally.
  task automatic test_reset_midflight();
    int stale = 0;
    out_ready = 1'b1;
    drive(1'b1, 16'd1036, 16'd414, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd5045, 16'd45042, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'd32768, 16'd1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    checkCount++;
    if ({out_valid, D} !== {1'b1, 16'd622})
      $display("[TB] FAIL midreset_pre: got valid=%b D=%0d required valid=1 D=622", out_valid, D);
    else passCount++;
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({out_valid, D, bout, ovf, zero, in_ready} !== {20'h0, 1'b1})
      $display("[TB] FAIL midreset_async: got valid=%b D=%0d in_ready=%b required valid=0 D=0 in_ready=1",
               out_valid, D, in_ready);
    else passCount++;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      @(posedge clk);
      #1;
    end
    checkCount++;
    if (stale != 0)
      $display("[TB] FAIL midreset_stale: got %0d stale results required 0", stale);
    else passCount++;
    test_vector("midreset_fresh", 16'd414, 16'd414, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    $display("[TB] starting cla_sub_pipe_16bit bench");
    test_reset();
    test_vector("basic",       16'd1036,  16'd414,   1'b0, 16'd622,   1'b0, 1'b0, 1'b0);
    test_vector("borrow_out",  16'd5045,  16'd45042, 1'b0, 16'd25539, 1'b1, 1'b0, 1'b0);
    test_vector("signed_ovf",  16'd32768, 16'd1,     1'b0, 16'd32767, 1'b0, 1'b1, 1'b0);
    test_vector("borrow_in",   16'd0,     16'd0,     1'b1, 16'd65535, 1'b1, 1'b0, 1'b0);
    test_vector("zero_result", 16'd65535, 16'd65535, 1'b0, 16'd0,     1'b0, 1'b0, 1'b1);
    test_vector("neg_ovf",     16'd32767, 16'd65535, 1'b0, 16'd32768, 1'b1, 1'b1, 1'b0);
    test_bubbles();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
